// File: rtl/btn_event_decoder.sv
// Purpose : turns the debounced button level into 1-cycle UI events
//           (press, release, short-click, long-press, auto-repeat) plus a held level.
// Latency : every output is registered; an event is visible 1 cycle after the
//           clock edge that samples the input change.
// Backpressure: none; events are fire-and-forget pulses, consumers must sample every cycle.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_btn_sync  debounced level synchronous to i_clk (1 = pressed)
//   o_press     pulse: button went down
//   o_release   pulse: button went up
//   o_short     pulse alongside o_release when no o_long was issued for this press
//   o_long      pulse once per press when the hold reaches LONG_CYCLES
//   o_repeat    pulse train every REPEAT_CYCLES while held after o_long
//   o_held      level: 1 from the o_press cycle up to the cycle before o_release
//
// Build option: define BTN_AUTO_REPEAT_EN to enable o_repeat and its counter;
// without it o_repeat is tied 0 and LONG_HELD simply waits for the release.

module btn_event_decoder #(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter int unsigned REPEAT_MS     = 200
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_sync,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  // Must be >= 2 so PRESSED lasts at least one counting cycle.
  localparam int unsigned LONG_CYCLES = (CLK_FREQ / 1000) * LONG_PRESS_MS;
  localparam logic [31:0] LONG_LAST   = 32'(LONG_CYCLES - 1);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned REPEAT_CYCLES = (CLK_FREQ / 1000) * REPEAT_MS;
  localparam logic [31:0] REP_LAST      = 32'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESSED   = 2'd1,
    S_LONG_HELD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        btn_q;
  logic        rise, fall;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        press_d, release_d, short_d, long_d, repeat_d;

`ifdef BTN_AUTO_REPEAT_EN
  logic [31:0] rep_cnt_q, rep_cnt_d;
`endif

  assign rise = i_btn_sync & ~btn_q;
  assign fall = ~i_btn_sync & btn_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d    = S_PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end

      S_PRESSED: begin
        // Release beats the threshold: a fall seen in the threshold cycle is
        // still a short click.
        if (fall) begin
          state_d    = S_IDLE;
          release_d  = 1'b1;
          short_d    = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d    = S_LONG_HELD;
          long_d     = 1'b1;
          hold_cnt_d = '0;
`ifdef BTN_AUTO_REPEAT_EN
          rep_cnt_d  = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end

      S_LONG_HELD: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          // Free-running period counter; wraps on each repeat tick.
          if (rep_cnt_q == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 32'd1;
          end
`endif
        end
      end

      default: begin
        state_d    = S_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      btn_q      <= 1'b0;
      hold_cnt_q <= '0;
      o_press    <= 1'b0;
      o_release  <= 1'b0;
      o_short    <= 1'b0;
      o_long     <= 1'b0;
      o_held     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= i_btn_sync;
      hold_cnt_q <= hold_cnt_d;
      o_press    <= press_d;
      o_release  <= release_d;
      o_short    <= short_d;
      o_long     <= long_d;
      // Tracks the next state so o_held rises with o_press and falls with o_release.
      o_held     <= (state_d != S_IDLE);
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rep_cnt_q <= '0;
      o_repeat  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      o_repeat  <= repeat_d;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = repeat_d;
  assign o_repeat      = 1'b0;
`endif

endmodule
